instr_sequencer: RTL and testbench

- Parametrised control-step sequencer that generates the datapath strobes previously hand-sequenced per test (T0..T7).
- Runs fetch, then decode, then execute for load, load-immediate, store, register-register ALU, NOP and HALT.
- Stretches any memory step until mem_ready is high.
- Sits between the IR/memory interface and DataPath; its strobe outputs map one-to-one onto DataPath control inputs.

---
 rtl/instr_sequencer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control-step FSM producing the DataPath strobes.
// Optional macro WAIT_TIMEOUT_EN bounds each memory wait to WAIT_MAX cycles and adds a FAULT state.
module instr_sequencer #(
    parameter int DATA_W   = 32,
    parameter int OP_W     = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              run,
    input  logic [DATA_W-1:0] ir,
    input  logic              mem_ready,
    output logic              pc_out,
    output logic              mar_in,
    output logic              inc_pc,
    output logic              z_in,
    output logic              zlo_out,
    output logic              pc_in,
    output logic              read,
    output logic              write,
    output logic              mdr_in,
    output logic              mdr_out,
    output logic              ir_in,
    output logic              gra,
    output logic              grb,
    output logic              grc,
    output logic              r_in,
    output logic              r_out,
    output logic              ba_out,
    output logic              y_in,
    output logic              c_out,
    output logic [OP_W-1:0]   alu_op,
    output logic              done,
    output logic              halted,
`ifdef WAIT_TIMEOUT_EN
    output logic              fault,
`endif
    output logic [3:0]        step
);

    localparam logic [OP_W-1:0] OP_LD     = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDI    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ST     = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ALU_LO = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ALU_HI = OP_W'(15);
    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(3);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T1W   = 4'd3,
        S_T2    = 4'd4,
        S_T3    = 4'd5,
        S_T4    = 4'd6,
        S_T5    = 4'd7,
        S_T6    = 4'd8,
        S_T6W   = 4'd9,
        S_T7    = 4'd10,
        S_HALT  = 4'd11,
        S_FAULT = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        C_LD,
        C_LDI,
        C_ST,
        C_ALU,
        C_NOP,
        C_HALT
    } op_class_t;

    state_t          state;
    state_t          state_next;
    state_t          eoi_state;
    op_class_t       cls;
    logic [OP_W-1:0] opcode;
    logic            unused_bits;

    assign opcode    = ir[DATA_W-1 -: OP_W];
    assign eoi_state = run ? S_T0 : S_IDLE;
    assign step      = state;

    // Only the opcode field steers the sequence; the operand fields belong to DataPath.
`ifdef WAIT_TIMEOUT_EN
    assign unused_bits = ^ir[DATA_W-OP_W-1:0];
`else
    assign unused_bits = ^{ir[DATA_W-OP_W-1:0], (WAIT_MAX > 0)};
`endif

    always_comb begin
        cls = C_NOP;
        if (opcode == OP_LD) begin
            cls = C_LD;
        end else if (opcode == OP_LDI) begin
            cls = C_LDI;
        end else if (opcode == OP_ST) begin
            cls = C_ST;
        end else if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
            cls = C_ALU;
        end else if (opcode == OP_HALT) begin
            cls = C_HALT;
        end
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             wait_expired;

    // wait_cnt_inc counts the current wait cycle too, so FAULT follows exactly WAIT_MAX wait cycles.
    assign wait_cnt_inc = wait_cnt + CNT_W'(1);
    assign wait_expired = (wait_cnt_inc == CNT_W'(WAIT_MAX));
    assign fault        = (state == S_FAULT);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            wait_cnt <= '0;
        end else if (state_next == S_T1 || state_next == S_T6) begin
            wait_cnt <= '0;
        end else if (state == S_T1W || state == S_T6W) begin
            wait_cnt <= wait_cnt_inc;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_out     = 1'b0;
        mar_in     = 1'b0;
        inc_pc     = 1'b0;
        z_in       = 1'b0;
        zlo_out    = 1'b0;
        pc_in      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        r_in       = 1'b0;
        r_out      = 1'b0;
        ba_out     = 1'b0;
        y_in       = 1'b0;
        c_out      = 1'b0;
        alu_op     = '0;
        done       = 1'b0;
        halted     = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_next = S_T0;
            end
            S_T0: begin
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                inc_pc     = 1'b1;
                z_in       = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                zlo_out    = 1'b1;
                pc_in      = 1'b1;
                read       = 1'b1;
                mdr_in     = 1'b1;
                state_next = mem_ready ? S_T2 : S_T1W;
            end
            S_T1W: begin
                read   = 1'b1;
                mdr_in = 1'b1;
                if (mem_ready) begin
                    state_next = S_T2;
                end
`ifdef WAIT_TIMEOUT_EN
                else if (wait_expired) begin
                    state_next = S_FAULT;
                end
`endif
            end
            S_T2: begin
                mdr_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                case (cls)
                    C_LD, C_LDI, C_ST: begin
                        grb        = 1'b1;
                        ba_out     = 1'b1;
                        y_in       = 1'b1;
                        state_next = S_T4;
                    end
                    C_ALU: begin
                        grb        = 1'b1;
                        r_out      = 1'b1;
                        y_in       = 1'b1;
                        state_next = S_T4;
                    end
                    C_HALT: begin
                        state_next = S_HALT;
                    end
                    default: begin
                        done       = 1'b1;
                        state_next = eoi_state;
                    end
                endcase
            end
            S_T4: begin
                z_in       = 1'b1;
                state_next = S_T5;
                if (cls == C_ALU) begin
                    grc    = 1'b1;
                    r_out  = 1'b1;
                    alu_op = opcode;
                end else begin
                    c_out  = 1'b1;
                    alu_op = OP_ADD;
                end
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (cls == C_LD || cls == C_ST) begin
                    mar_in     = 1'b1;
                    state_next = S_T6;
                end else begin
                    gra        = 1'b1;
                    r_in       = 1'b1;
                    done       = 1'b1;
                    state_next = eoi_state;
                end
            end
            S_T6: begin
                mdr_in = 1'b1;
                if (cls == C_ST) begin
                    gra   = 1'b1;
                    r_out = 1'b1;
                    write = 1'b1;
                end else begin
                    read  = 1'b1;
                end
                state_next = mem_ready ? S_T7 : S_T6W;
            end
            S_T6W: begin
                // A store already latched MDR in T6; only a load keeps capturing.
                if (cls == C_ST) begin
                    write  = 1'b1;
                end else begin
                    read   = 1'b1;
                    mdr_in = 1'b1;
                end
                if (mem_ready) begin
                    state_next = S_T7;
                end
`ifdef WAIT_TIMEOUT_EN
                else if (wait_expired) begin
                    state_next = S_FAULT;
                end
`endif
            end
            S_T7: begin
                done       = 1'b1;
                state_next = eoi_state;
                if (cls != C_ST) begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef WAIT_TIMEOUT_EN
            S_FAULT: begin
                state_next = S_FAULT;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: per-cycle strobe, step and alu_op checks for each scenario.
// Builds with or without WAIT_TIMEOUT_EN; the wait scenario adapts to the macro.
module tb_instr_sequencer;

    logic        clock;
    logic        clear_n;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic        pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, read, write;
    logic        mdr_in, mdr_out, ir_in, gra, grb, grc, r_in, r_out, ba_out, y_in, c_out;
    logic [4:0]  alu_op;
    logic        done, halted;
`ifdef WAIT_TIMEOUT_EN
    logic        fault;
`endif
    logic [3:0]  step;
    logic [20:0] obs;

    int checks = 0;
    int errors = 0;

    localparam logic [20:0] M_PC_OUT  = 21'd1 << 20;
    localparam logic [20:0] M_MAR_IN  = 21'd1 << 19;
    localparam logic [20:0] M_INC_PC  = 21'd1 << 18;
    localparam logic [20:0] M_Z_IN    = 21'd1 << 17;
    localparam logic [20:0] M_ZLO_OUT = 21'd1 << 16;
    localparam logic [20:0] M_PC_IN   = 21'd1 << 15;
    localparam logic [20:0] M_READ    = 21'd1 << 14;
    localparam logic [20:0] M_WRITE   = 21'd1 << 13;
    localparam logic [20:0] M_MDR_IN  = 21'd1 << 12;
    localparam logic [20:0] M_MDR_OUT = 21'd1 << 11;
    localparam logic [20:0] M_IR_IN   = 21'd1 << 10;
    localparam logic [20:0] M_GRA     = 21'd1 << 9;
    localparam logic [20:0] M_GRB     = 21'd1 << 8;
    localparam logic [20:0] M_GRC     = 21'd1 << 7;
    localparam logic [20:0] M_R_IN    = 21'd1 << 6;
    localparam logic [20:0] M_R_OUT   = 21'd1 << 5;
    localparam logic [20:0] M_BA_OUT  = 21'd1 << 4;
    localparam logic [20:0] M_Y_IN    = 21'd1 << 3;
    localparam logic [20:0] M_C_OUT   = 21'd1 << 2;
    localparam logic [20:0] M_DONE    = 21'd1 << 1;
    localparam logic [20:0] M_HALTED  = 21'd1;

    localparam logic [20:0] E_T0      = M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN;
    localparam logic [20:0] E_T1      = M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN;
    localparam logic [20:0] E_T1W     = M_READ | M_MDR_IN;
    localparam logic [20:0] E_T2      = M_MDR_OUT | M_IR_IN;
    localparam logic [20:0] E_T3_MEM  = M_GRB | M_BA_OUT | M_Y_IN;
    localparam logic [20:0] E_T3_ALU  = M_GRB | M_R_OUT | M_Y_IN;
    localparam logic [20:0] E_T4_MEM  = M_C_OUT | M_Z_IN;
    localparam logic [20:0] E_T4_ALU  = M_GRC | M_R_OUT | M_Z_IN;
    localparam logic [20:0] E_T5_MEM  = M_ZLO_OUT | M_MAR_IN;
    localparam logic [20:0] E_T5_REG  = M_ZLO_OUT | M_GRA | M_R_IN | M_DONE;
    localparam logic [20:0] E_T6_LD   = M_READ | M_MDR_IN;
    localparam logic [20:0] E_T6_ST   = M_GRA | M_R_OUT | M_MDR_IN | M_WRITE;
    localparam logic [20:0] E_T6W_ST  = M_WRITE;
    localparam logic [20:0] E_T7_LD   = M_MDR_OUT | M_GRA | M_R_IN | M_DONE;

    localparam logic [3:0] P_IDLE = 4'd0, P_T0 = 4'd1, P_T1 = 4'd2, P_T1W = 4'd3, P_T2 = 4'd4;
    localparam logic [3:0] P_T3 = 4'd5, P_T4 = 4'd6, P_T5 = 4'd7, P_T6 = 4'd8, P_T6W = 4'd9;
    localparam logic [3:0] P_T7 = 4'd10, P_HALT = 4'd11, P_FAULT = 4'd12;

    localparam logic [31:0] IR_LD   = 32'h0080_0005;
    localparam logic [31:0] IR_LDI  = 32'h0800_0000;
    localparam logic [31:0] IR_ST   = 32'h1000_0000;
    localparam logic [31:0] IR_ALU4 = 32'h2000_0000;
    localparam logic [31:0] IR_UNDF = 32'h8000_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    assign obs = {pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, read, write, mdr_in, mdr_out,
                  ir_in, gra, grb, grc, r_in, r_out, ba_out, y_in, c_out, done, halted};

    instr_sequencer #(
        .DATA_W(32),
`ifdef WAIT_TIMEOUT_EN
        .WAIT_MAX(4),
`endif
        .OP_W(5)
    ) dut (
        .clock(clock), .clear_n(clear_n), .run(run), .ir(ir), .mem_ready(mem_ready),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .zlo_out(zlo_out),
        .pc_in(pc_in), .read(read), .write(write), .mdr_in(mdr_in), .mdr_out(mdr_out),
        .ir_in(ir_in), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
        .ba_out(ba_out), .y_in(y_in), .c_out(c_out), .alu_op(alu_op), .done(done),
        .halted(halted),
`ifdef WAIT_TIMEOUT_EN
        .fault(fault),
`endif
        .step(step)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply_reset();
        clear_n   = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = IR_LD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i == 0) continue;
            checks++;
            if (obs !== 21'd0) begin errors++; $display("FAIL reset_strobes cycle %0d: got %h expected 0", i, obs); end
            checks++;
            if (step !== P_IDLE) begin errors++; $display("FAIL reset_step cycle %0d: got %0d expected 0", i, step); end
            checks++;
            if (alu_op !== 5'd0) begin errors++; $display("FAIL reset_alu_op cycle %0d: got %0d expected 0", i, alu_op); end
        end
    endtask

    task automatic test_ld_zero_wait();
        logic [20:0] ev [9];
        logic [3:0]  es [9];
        logic [4:0]  ea [9];
        ev = '{E_T0, E_T1, E_T2, E_T3_MEM, E_T4_MEM, E_T5_MEM, E_T6_LD, E_T7_LD, E_T0};
        es = '{P_T0, P_T1, P_T2, P_T3, P_T4, P_T5, P_T6, P_T7, P_T0};
        ea = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_LD;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL ld_strobes cycle %0d: got %h expected %h", i + 1, obs, ev[i]); end
            checks++;
            if (step !== es[i]) begin errors++; $display("FAIL ld_step cycle %0d: got %0d expected %0d", i + 1, step, es[i]); end
            checks++;
            if (alu_op !== ea[i]) begin errors++; $display("FAIL ld_alu_op cycle %0d: got %0d expected %0d", i + 1, alu_op, ea[i]); end
        end
    endtask

    task automatic test_fetch_wait();
        logic [20:0] ev [12];
        logic [3:0]  es [12];
        ev = '{E_T0, E_T1, E_T1W, E_T1W, E_T1W, E_T2, E_T3_MEM, E_T4_MEM, E_T5_MEM, E_T6_LD, E_T7_LD, 21'd0};
        es = '{P_T0, P_T1, P_T1W, P_T1W, P_T1W, P_T2, P_T3, P_T4, P_T5, P_T6, P_T7, P_IDLE};
        apply_reset();
        run = 1'b1; mem_ready = 1'b0; ir = IR_LD;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL fetchwait_strobes cycle %0d: got %h expected %h", i + 1, obs, ev[i]); end
            checks++;
            if (step !== es[i]) begin errors++; $display("FAIL fetchwait_step cycle %0d: got %0d expected %0d", i + 1, step, es[i]); end
            mem_ready = (i >= 4);
            if (i == 10) run = 1'b0;
        end
    endtask

    task automatic test_alu();
        logic [20:0] ev [8];
        logic [3:0]  es [8];
        logic [4:0]  ea [8];
        ev = '{E_T0, E_T1, E_T2, E_T3_ALU, E_T4_ALU, E_T5_REG, 21'd0, 21'd0};
        es = '{P_T0, P_T1, P_T2, P_T3, P_T4, P_T5, P_IDLE, P_IDLE};
        ea = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_ALU4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL alu_strobes cycle %0d: got %h expected %h", i + 1, obs, ev[i]); end
            checks++;
            if (step !== es[i]) begin errors++; $display("FAIL alu_step cycle %0d: got %0d expected %0d", i + 1, step, es[i]); end
            checks++;
            if (alu_op !== ea[i]) begin errors++; $display("FAIL alu_alu_op cycle %0d: got %0d expected %0d", i + 1, alu_op, ea[i]); end
            if (i == 5) run = 1'b0;
        end
    endtask

    task automatic test_st_wait();
        logic [20:0] ev [11];
        logic [3:0]  es [11];
        logic [4:0]  ea [11];
        ev = '{E_T0, E_T1, E_T2, E_T3_MEM, E_T4_MEM, E_T5_MEM, E_T6_ST, E_T6W_ST, E_T6W_ST, M_DONE, 21'd0};
        es = '{P_T0, P_T1, P_T2, P_T3, P_T4, P_T5, P_T6, P_T6W, P_T6W, P_T7, P_IDLE};
        ea = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_ST;
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL st_strobes cycle %0d: got %h expected %h", i + 1, obs, ev[i]); end
            checks++;
            if (step !== es[i]) begin errors++; $display("FAIL st_step cycle %0d: got %0d expected %0d", i + 1, step, es[i]); end
            checks++;
            if (alu_op !== ea[i]) begin errors++; $display("FAIL st_alu_op cycle %0d: got %0d expected %0d", i + 1, alu_op, ea[i]); end
            mem_ready = !(i == 6 || i == 7);
            if (i == 9) run = 1'b0;
        end
    endtask

    task automatic test_halt_reset();
        logic [20:0] ev5 [6];
        logic [3:0]  es5 [6];
        logic [20:0] exp_v;
        logic [3:0]  exp_s;
        ev5 = '{E_T0, E_T1, E_T2, E_T3_MEM, E_T4_MEM, E_T5_MEM};
        es5 = '{P_T0, P_T1, P_T2, P_T3, P_T4, P_T5};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_HALT;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            exp_v = (i == 0) ? E_T0 : (i == 1) ? E_T1 : (i == 2) ? E_T2 : (i == 3) ? 21'd0 : M_HALTED;
            exp_s = (i == 0) ? P_T0 : (i == 1) ? P_T1 : (i == 2) ? P_T2 : (i == 3) ? P_T3 : P_HALT;
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL halt_strobes cycle %0d: got %h expected %h", i + 1, obs, exp_v); end
            checks++;
            if (step !== exp_s) begin errors++; $display("FAIL halt_step cycle %0d: got %0d expected %0d", i + 1, step, exp_s); end
        end
        clear_n = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== 21'd0) begin errors++; $display("FAIL halt_exit_strobes: got %h expected 0", obs); end
        checks++;
        if (step !== P_IDLE) begin errors++; $display("FAIL halt_exit_step: got %0d expected 0", step); end
        clear_n = 1'b1; ir = IR_LD;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== ev5[i]) begin errors++; $display("FAIL midld_strobes cycle %0d: got %h expected %h", i + 1, obs, ev5[i]); end
            checks++;
            if (step !== es5[i]) begin errors++; $display("FAIL midld_step cycle %0d: got %0d expected %0d", i + 1, step, es5[i]); end
        end
        clear_n = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== 21'd0) begin errors++; $display("FAIL midld_reset_strobes: got %h expected 0", obs); end
        checks++;
        if (step !== P_IDLE) begin errors++; $display("FAIL midld_reset_step: got %0d expected 0", step); end
        checks++;
        if (alu_op !== 5'd0) begin errors++; $display("FAIL midld_reset_alu_op: got %0d expected 0", alu_op); end
        clear_n = 1'b1; run = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [20:0] ev [15];
        logic [3:0]  es [15];
        logic [4:0]  ea [15];
        ev = '{E_T0, E_T1, E_T2, M_DONE, E_T0, E_T1, E_T2, E_T3_MEM, E_T4_MEM, E_T5_REG,
               E_T0, E_T1, E_T2, M_DONE, 21'd0};
        es = '{P_T0, P_T1, P_T2, P_T3, P_T0, P_T1, P_T2, P_T3, P_T4, P_T5,
               P_T0, P_T1, P_T2, P_T3, P_IDLE};
        ea = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0,
               5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_NOP;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL b2b_strobes cycle %0d: got %h expected %h", i + 1, obs, ev[i]); end
            checks++;
            if (step !== es[i]) begin errors++; $display("FAIL b2b_step cycle %0d: got %0d expected %0d", i + 1, step, es[i]); end
            checks++;
            if (alu_op !== ea[i]) begin errors++; $display("FAIL b2b_alu_op cycle %0d: got %0d expected %0d", i + 1, alu_op, ea[i]); end
            if (i == 4) ir = IR_LDI;
            if (i == 10) ir = IR_UNDF;
            if (i == 13) run = 1'b0;
        end
    endtask

    task automatic test_ir_change();
        logic [20:0] ev [7];
        logic [3:0]  es [7];
        ev = '{E_T0, E_T1, E_T2, E_T3_MEM, E_T4_MEM, E_T5_REG, 21'd0};
        es = '{P_T0, P_T1, P_T2, P_T3, P_T4, P_T5, P_IDLE};
        apply_reset();
        run = 1'b1; mem_ready = 1'b1; ir = IR_HALT;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL irchg_strobes cycle %0d: got %h expected %h", i + 1, obs, ev[i]); end
            checks++;
            if (step !== es[i]) begin errors++; $display("FAIL irchg_step cycle %0d: got %0d expected %0d", i + 1, step, es[i]); end
            if (i == 0) begin ir = IR_NOP; run = 1'b0; end
            if (i == 1) ir = IR_LDI;
        end
    endtask

    task automatic test_wait_limit();
        logic [20:0] exp_v;
        logic [3:0]  exp_s;
        apply_reset();
        run = 1'b1; mem_ready = 1'b0; ir = IR_LD;
`ifdef WAIT_TIMEOUT_EN
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            exp_v = (i == 0) ? E_T0 : (i == 1) ? E_T1 : (i < 6) ? E_T1W : 21'd0;
            exp_s = (i == 0) ? P_T0 : (i == 1) ? P_T1 : (i < 6) ? P_T1W : P_FAULT;
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL timeout_strobes cycle %0d: got %h expected %h", i + 1, obs, exp_v); end
            checks++;
            if (step !== exp_s) begin errors++; $display("FAIL timeout_step cycle %0d: got %0d expected %0d", i + 1, step, exp_s); end
            checks++;
            if (fault !== (i >= 6)) begin errors++; $display("FAIL timeout_fault cycle %0d: got %0b expected %0b", i + 1, fault, (i >= 6)); end
        end
`else
        for (int i = 0; i < 112; i++) begin
            @(negedge clock);
            exp_v = (i == 0) ? E_T0 : (i == 1) ? E_T1 : E_T1W;
            exp_s = (i == 0) ? P_T0 : (i == 1) ? P_T1 : P_T1W;
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL unbounded_strobes cycle %0d: got %h expected %h", i + 1, obs, exp_v); end
            checks++;
            if (step !== exp_s) begin errors++; $display("FAIL unbounded_step cycle %0d: got %0d expected %0d", i + 1, step, exp_s); end
        end
`endif
    endtask

    initial begin
        clear_n = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'd0;
        test_reset();
        test_ld_zero_wait();
        test_fetch_wait();
        test_alu();
        test_st_wait();
        test_halt_reset();
        test_back_to_back();
        test_ir_change();
        test_wait_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
